syn_current_accum: RTL and testbench

- Upstream stage of the Izhikevich neuron datapath.
- Converts a vector of presynaptic spikes into a decaying synaptic current, in 16-bit signed Q1.15.
- Produces the pre-scaled drive word consumed on the neuron's i_mul_h input.
- Processes one synapse per clock, serially, with a per-step start strobe, so a single adder/multiplier is shared.

---
 rtl/snn_fixed_pkg.sv | 24 ++
 rtl/syn_weight_rf.sv | 20 ++
 rtl/syn_current_accum.sv | 72 +++++++
 tb/tb_syn_current_accum.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/snn_fixed_pkg.sv
// snn_fixed_pkg: Q1.15 fixed-point helpers and FSM states shared by the SNN datapath
package snn_fixed_pkg;
  localparam logic [15:0] Q15_MAX = 16'h7fff;
  localparam logic [15:0] Q15_MIN = 16'h8001;
  typedef enum logic [1:0] {IDLE, ACCUM, SCALE} state_t;
  // Sign-magnitude product so rounding is symmetric (truncation toward zero)
  function automatic logic [15:0] q15_mul(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] ma, mb, m16;
    logic [31:0] p;
    logic [16:0] m;
    ma = a[15] ? -a : a;
    mb = b[15] ? -b : b;
    p = ma * mb;
    m = 17'(p >> 15);
    m16 = m > 17'd32767 ? 16'h7fff : m[15:0];
    return (a[15] ^ b[15]) ? -m16 : m16;
  endfunction
  // 8000 is never produced: the neuron multiplier treats it as a zero-magnitude operand
  function automatic logic [15:0] q15_sat_add(input logic [15:0] a, input logic [15:0] b);
    logic signed [16:0] s;
    s = {a[15], a} + {b[15], b};
    return s > 17'sd32767 ? Q15_MAX : s < -17'sd32767 ? Q15_MIN : s[15:0];
  endfunction
endpackage

// File: rtl/syn_weight_rf.sv
// syn_weight_rf: N_SYN x 16 weight register file, sync clear, one write port, comb read
module syn_weight_rf #(
  parameter int N_SYN = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [$clog2(N_SYN)-1:0] wr_addr_i,
  input  logic [15:0]              wr_data_i,
  input  logic [$clog2(N_SYN)-1:0] rd_addr_i,
  output logic [15:0]              rd_data_o
);
  logic [15:0] mem [N_SYN];
  always_ff @(posedge clk)
    if (!rst_n)
      for (int i = 0; i < N_SYN; i++) mem[i] <= '0;
    else if (wr_en_i)
      mem[wr_addr_i] <= wr_data_i;
  assign rd_data_o = mem[rd_addr_i];
endmodule

// File: rtl/syn_current_accum.sv
// syn_current_accum: serial decaying synaptic-current accumulator, one synapse per clock
module syn_current_accum
  import snn_fixed_pkg::*;
#(
  parameter int          N_SYN   = 8,
  parameter logic [15:0] DECAY   = 16'h7ae1,
  parameter logic [15:0] H_SCALE = 16'h0148,
  parameter logic [15:0] I_BIAS  = 16'h0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     step_i,
  input  logic [N_SYN-1:0]         spike_vec_i,
  input  logic                     wr_en_i,
  input  logic [$clog2(N_SYN)-1:0] wr_addr_i,
  input  logic [15:0]              wr_data_i,
  output logic [15:0]              i_syn_o,
  output logic [15:0]              i_mul_h_o,
  output logic                     valid_o,
  output logic                     busy_o,
  output logic                     overrun_o
);
  localparam int IW = $clog2(N_SYN);
  state_t state, state_nx;
  logic [N_SYN-1:0] snap;
  logic [15:0] acc, w_rd, biased;
  logic [IW-1:0] idx;
  syn_weight_rf #(.N_SYN(N_SYN)) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .rd_addr_i (idx),
    .rd_data_o (w_rd)
  );
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_nx;
  always_comb
    state_nx = state == IDLE  ? (step_i ? ACCUM : IDLE) :
               state == ACCUM ? (idx == IW'(N_SYN - 1) ? SCALE : ACCUM) : IDLE;
  always_comb
    busy_o = state != IDLE;
  assign biased = q15_sat_add(acc, I_BIAS);
  always_ff @(posedge clk)
    if (!rst_n) begin
      snap      <= '0;
      acc       <= '0;
      idx       <= '0;
      i_syn_o   <= '0;
      i_mul_h_o <= '0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (step_i && busy_o) overrun_o <= 1'b1;
      if (state == IDLE && step_i) begin
        snap <= spike_vec_i;
        acc  <= q15_mul(i_syn_o, DECAY);
        idx  <= '0;
      end
      if (state == ACCUM) begin
        if (snap[idx]) acc <= q15_sat_add(acc, w_rd);
        idx <= idx + 1'b1;
      end
      if (state == SCALE) begin
        i_syn_o   <= biased;
        i_mul_h_o <= q15_mul(biased, H_SCALE);
        valid_o   <= 1'b1;
      end
    end
endmodule

// File: tb/tb_syn_current_accum.sv
// tb_syn_current_accum: randomized + directed bench against a timeline model of the accumulator
module tb_syn_current_accum;
  localparam int N = 8;
  localparam logic [15:0] DECAY = 16'h7ae1, HS = 16'h0148, BIAS = 16'h0000;
  logic clk = 0, rst_n = 0, step_i = 0, wr_en_i = 0, valid_o, busy_o, overrun_o;
  logic [N-1:0] spike_vec_i = '0;
  logic [2:0] wr_addr_i = '0;
  logic [15:0] wr_data_i = '0, i_syn_o, i_mul_h_o;
  int checks = 0, errors = 0;
  bit armed = 0;
  syn_current_accum dut (
    .clk(clk), .rst_n(rst_n), .step_i(step_i), .spike_vec_i(spike_vec_i),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .i_syn_o(i_syn_o), .i_mul_h_o(i_mul_h_o), .valid_o(valid_o),
    .busy_o(busy_o), .overrun_o(overrun_o)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] m_mul(logic [15:0] a, logic [15:0] b);
    int sa, sb, m;
    sa = $signed(a);
    sb = $signed(b);
    m = ((sa < 0 ? -sa : sa) * (sb < 0 ? -sb : sb)) / 32768;
    if (m > 32767) m = 32767;
    return 16'(((sa < 0) != (sb < 0)) ? -m : m);
  endfunction
  function automatic logic [15:0] m_add(logic [15:0] a, logic [15:0] b);
    int s;
    s = $signed(a) + $signed(b);
    return 16'(s > 32767 ? 32767 : s < -32767 ? -32767 : s);
  endfunction
  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask
  // Model: an update accepted at edge t0 consumes synapse j at edge t0+1+j and publishes at t0+N+1
  logic [15:0] w [N];
  logic [15:0] e_syn, e_mulh, e_acc;
  logic [N-1:0] e_snap;
  bit e_valid, e_ovr, act;
  int t_rel;
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) w[i] = '0;
      e_syn = '0; e_mulh = '0; e_acc = '0; e_snap = '0;
      e_valid = 0; e_ovr = 0; act = 0; t_rel = 0; armed = 1;
    end else begin
      e_valid = 0;
      if (act) begin
        t_rel++;
        if (step_i) e_ovr = 1;
        if (t_rel <= N) begin
          if (e_snap[t_rel-1]) e_acc = m_add(e_acc, w[t_rel-1]);
        end else begin
          e_syn = m_add(e_acc, BIAS);
          e_mulh = m_mul(e_syn, HS);
          e_valid = 1;
          act = 0;
        end
      end else if (step_i) begin
        act = 1; t_rel = 0; e_snap = spike_vec_i; e_acc = m_mul(e_syn, DECAY);
      end
      if (wr_en_i) w[wr_addr_i] = wr_data_i;
    end
  end
  always @(negedge clk)
    if (armed) begin
      chk("valid", 16'(valid_o), 16'(e_valid));
      chk("busy", 16'(busy_o), 16'(act));
      chk("overrun", 16'(overrun_o), 16'(e_ovr));
      chk("i_syn", i_syn_o, e_syn);
      chk("i_mul_h", i_mul_h_o, e_mulh);
    end
  task automatic do_reset();
    @(negedge clk); rst_n = 0; step_i = 0; wr_en_i = 0;
    @(negedge clk); @(negedge clk); rst_n = 1;
  endtask
  task automatic wr(int a, logic [15:0] d);
    @(negedge clk); wr_en_i = 1; wr_addr_i = 3'(a); wr_data_i = d;
    @(negedge clk); wr_en_i = 0;
  endtask
  task automatic pulse(logic [N-1:0] s);
    @(negedge clk); step_i = 1; spike_vec_i = s;
    @(negedge clk); step_i = 0;
  endtask
  task automatic step_wait(logic [N-1:0] s, output int k);
    pulse(s);
    k = 1;
    while (!valid_o && k < 20) begin @(negedge clk); k++; end
  endtask
  int k, nv;
  initial begin
    do_reset();
    chk("rst_i_syn", i_syn_o, 16'h0000);
    chk("rst_busy", 16'(busy_o), 16'h0000);
    wr(0, 16'h1000);
    step_wait(8'h01, k);
    chk("latency", 16'(k), 16'd10);
    chk("single_i_syn", i_syn_o, 16'h1000);
    chk("single_mul_h", i_mul_h_o, 16'h0029);
    step_wait(8'h00, k);
    chk("decay_i_syn", i_syn_o, 16'h0f5c);
    chk("decay_mul_h", i_mul_h_o, 16'h0027);
    do_reset();
    for (int i = 0; i < N; i++) wr(i, 16'h2000);
    step_wait(8'hff, k);
    chk("possat_i_syn", i_syn_o, 16'h7fff);
    chk("possat_mul_h", i_mul_h_o, 16'h0147);
    do_reset();
    for (int i = 0; i < 4; i++) wr(i, 16'hc000);
    step_wait(8'h0f, k);
    chk("negsat_i_syn", i_syn_o, 16'h8001);
    chk("negsat_mul_h", i_mul_h_o, 16'hfeb9);
    do_reset();
    wr(0, 16'h1000);
    pulse(8'h01);
    @(negedge clk); @(negedge clk);
    step_i = 1; spike_vec_i = 8'hff;
    @(negedge clk); step_i = 0;
    nv = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); nv += int'(valid_o); end
    chk("ovr_flag", 16'(overrun_o), 16'h0001);
    chk("ovr_pulses", 16'(nv), 16'd1);
    chk("ovr_i_syn", i_syn_o, 16'h1000);
    chk("ovr_mul_h", i_mul_h_o, 16'h0029);
    do_reset();
    wr(0, 16'h1000);
    pulse(8'h01);
    repeat (4) @(negedge clk);
    rst_n = 0;
    @(negedge clk); rst_n = 1;
    chk("abort_busy", 16'(busy_o), 16'h0000);
    chk("abort_i_syn", i_syn_o, 16'h0000);
    nv = 0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); nv += int'(valid_o); end
    chk("abort_no_valid", 16'(nv), 16'd0);
    step_wait(8'hff, k);
    chk("abort_w_clear", i_syn_o, 16'h0000);
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      rst_n = ($urandom % 300) != 0;
      step_i = ($urandom % 5) == 0;
      spike_vec_i = N'($urandom);
      wr_en_i = ($urandom % 3) == 0;
      wr_addr_i = 3'($urandom);
      wr_data_i = ($urandom % 4 == 0) ? (($urandom % 2) ? 16'h7fff : 16'h8000) : 16'($urandom);
    end
    @(negedge clk); rst_n = 1; step_i = 0; wr_en_i = 0;
    repeat (15) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
